rs_syndrome_engine: RTL and testbench

- Streaming syndrome calculator for the Reed-Solomon decoder datapath. It sits directly upstream of the Berlekamp-Massey stage.
- Accepts one received codeword as a byte stream, highest-degree coefficient first.
- Evaluates the codeword at nsyn consecutive roots over GF(2^8) by Horner's rule, using one shared multiplier time-multiplexed across the syndromes.
- Streams the syndromes out over a valid/ready handshake, together with a nonzero (error-present) flag.

---
 rtl/rs_syndrome_engine_pkg.sv | 10 +
 rtl/rs_syndrome_engine_if.sv | 16 +
 rtl/rs_syndrome_engine_gf_mul8.sv | 20 ++
 rtl/rs_syndrome_engine.sv | 142 ++++++++++++++
 tb/tb_rs_syndrome_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_syndrome_engine_pkg.sv
// rs_pkg: shared GF(2^8) constants, FSM state type and the xtime helper for the syndrome engine
package rs_pkg;
    localparam int GF_W = 8;
    localparam logic [GF_W-1:0] ALPHA = 8'h02;
    localparam logic [GF_W-1:0] DEFAULT_POLY = 8'h1D;
    typedef enum logic [1:0] {IDLE, RECV, ACC, EMIT} state_t;
    function automatic logic [GF_W-1:0] xtime(input logic [GF_W-1:0] a, input logic [GF_W-1:0] poly);
        return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? poly : '0);
    endfunction
endpackage

// File: rtl/rs_syndrome_engine_if.sv
// rs_syndrome_engine_if: byte input stream and syndrome output stream; the engine uses the slave view
interface rs_syndrome_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       syn_valid;
    logic       syn_ready;
    logic [7:0] syn_data;
    logic [5:0] syn_index;
    logic       syn_last;
    logic       syn_nonzero;
    modport master (output in_valid, in_data, syn_ready,
                    input  in_ready, syn_valid, syn_data, syn_index, syn_last, syn_nonzero);
    modport slave  (input  in_valid, in_data, syn_ready,
                    output in_ready, syn_valid, syn_data, syn_index, syn_last, syn_nonzero);
endinterface

// File: rtl/rs_syndrome_engine_gf_mul8.sv
// gf_mul8: combinational GF(2^8) multiply, shift-and-add over 8 partial products with a runtime polynomial
module gf_mul8
    import rs_pkg::*;
(
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    input  logic [GF_W-1:0] i_poly,
    output logic [GF_W-1:0] o_p
);
    logic [GF_W-1:0] w_sh;
    // accumulate a*x^i for every set bit of b, reducing a*x^i as it is shifted
    always_comb begin
        o_p  = '0;
        w_sh = i_a;
        for (int i = 0; i < GF_W; i++) begin
            o_p  = o_p ^ (i_b[i] ? w_sh : '0);
            w_sh = xtime(w_sh, i_poly);
        end
    end
endmodule

// File: rtl/rs_syndrome_engine.sv
// rs_syndrome_engine: Horner-rule syndrome calculator sharing one GF multiplier across all syndromes
module rs_syndrome_engine
    import rs_pkg::*;
#(
    parameter int MAX_PARITY = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_prim_poly,
    input  logic [7:0] cfg_first_root,
    input  logic [5:0] cfg_nsyn,
    input  logic [7:0] cfg_block_len,
    rs_syndrome_engine_if.slave bus,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);
    localparam int IW = $clog2(MAX_PARITY);
    localparam logic [6:0] MAXP = 7'(MAX_PARITY);

    state_t          r_state, w_next;
    logic [GF_W-1:0] r_poly, r_fcr, r_root, r_byte, r_len, r_cnt;
    logic [5:0]      r_nsyn, r_j, r_k;
    logic [GF_W-1:0] r_syn [MAX_PARITY];
    logic            r_nz, r_done, r_cfg_err;
    logic [GF_W-1:0] w_prod, w_new;
    logic            w_cfg_ok, w_last_j, w_last_byte, w_syn_last, w_nz, w_emit;

    assign w_cfg_ok    = cfg_nsyn != '0 && {1'b0, cfg_nsyn} <= MAXP && cfg_block_len != '0;
    assign w_last_j    = r_j == r_nsyn - 6'd1;
    assign w_last_byte = 8'(r_cnt + 8'd1) == r_len;
    assign w_syn_last  = r_k == r_nsyn - 6'd1;
    assign w_emit      = r_state == EMIT;
    assign w_new       = w_prod ^ r_byte;

    gf_mul8 u_mul (.i_a(r_syn[r_j[IW-1:0]]), .i_b(r_root), .i_poly(r_poly), .o_p(w_prod));

    // error-present flag as it will stand once the current ACC write lands
    always_comb begin
        w_nz = w_new != '0;
        for (int i = 0; i < MAX_PARITY; i++)
            w_nz = w_nz | (i != int'(r_j) && r_syn[i] != '0);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state and handshake strobes; abort overrides everything
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.syn_valid = 1'b0;
        case (r_state)
            IDLE: w_next = (start && w_cfg_ok) ? RECV : IDLE;
            RECV: begin
                bus.in_ready = 1'b1;
                w_next       = bus.in_valid ? ACC : RECV;
            end
            ACC:  w_next = !w_last_j ? ACC : (w_last_byte ? EMIT : RECV);
            EMIT: begin
                bus.syn_valid = 1'b1;
                w_next        = (bus.syn_ready && w_syn_last) ? IDLE : EMIT;
            end
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

    // configuration latch, syndrome file, counters and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poly    <= DEFAULT_POLY;
            r_fcr     <= ALPHA;
            r_root    <= '0;
            r_byte    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_nsyn    <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_nz      <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < MAX_PARITY; i++) r_syn[i] <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (!abort) begin
                case (r_state)
                    IDLE: if (start) begin
                        if (w_cfg_ok) begin
                            r_poly <= cfg_prim_poly;
                            r_fcr  <= cfg_first_root;
                            r_nsyn <= cfg_nsyn;
                            r_len  <= cfg_block_len;
                            r_cnt  <= '0;
                            r_nz   <= 1'b0;
                            for (int i = 0; i < MAX_PARITY; i++) r_syn[i] <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    RECV: if (bus.in_valid) begin
                        r_byte <= bus.in_data;
                        r_j    <= '0;
                        r_root <= r_fcr;
                    end
                    ACC: begin
                        r_syn[r_j[IW-1:0]] <= w_new;
                        r_root             <= xtime(r_root, r_poly);
                        r_j                <= r_j + 6'd1;
                        if (w_last_j) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (w_last_byte) begin
                                r_nz <= w_nz;
                                r_k  <= '0;
                            end
                        end
                    end
                    EMIT: if (bus.syn_ready) begin
                        r_k    <= r_k + 6'd1;
                        r_done <= w_syn_last;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy            = r_state != IDLE;
    assign done            = r_done;
    assign cfg_err         = r_cfg_err;
    assign bus.syn_data    = w_emit ? r_syn[r_k[IW-1:0]] : '0;
    assign bus.syn_index   = w_emit ? r_k : '0;
    assign bus.syn_last    = w_emit && w_syn_last;
    assign bus.syn_nonzero = w_emit && r_nz;
endmodule

// File: tb/tb_rs_syndrome_engine.sv
// tb_rs_syndrome_engine: directed and randomized checks against a log/antilog polynomial-evaluation model
module tb_rs_syndrome_engine;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [7:0] cfg_prim_poly = 0, cfg_first_root = 0, cfg_block_len = 0;
    logic [5:0] cfg_nsyn = 0;
    logic       busy, done, cfg_err;
    int         total = 0, bad = 0, cyc_cnt = 0, start_cyc = 0, first_lat = 0;
    logic [7:0] blk [256];
    logic [7:0] exp_syn [32];
    logic       exp_nz;
    int         exp_tab [255];
    int         log_tab [256];
    logic [7:0] polys [3] = '{8'h1D, 8'h2B, 8'h63};

    rs_syndrome_engine_if vif ();

    rs_syndrome_engine #(.MAX_PARITY(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_prim_poly(cfg_prim_poly), .cfg_first_root(cfg_first_root),
        .cfg_nsyn(cfg_nsyn), .cfg_block_len(cfg_block_len),
        .bus(vif), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_in_ready"}, 32'(vif.in_ready), 0);
        chk({tag, "_syn_valid"}, 32'(vif.syn_valid), 0);
        chk({tag, "_syn_data"}, 32'(vif.syn_data), 0);
        chk({tag, "_syn_index"}, 32'(vif.syn_index), 0);
        chk({tag, "_syn_last"}, 32'(vif.syn_last), 0);
        chk({tag, "_syn_nonzero"}, 32'(vif.syn_nonzero), 0);
    endtask

    task automatic build(input logic [7:0] poly);
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = e;
            log_tab[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e = e ^ (256 | int'(poly));
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return 8'(exp_tab[(log_tab[a] + log_tab[b]) % 255]);
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] a, input int d);
        if (d == 0) return 8'h01;
        if (a == 0) return 8'h00;
        return 8'(exp_tab[(log_tab[a] * d) % 255]);
    endfunction

    task automatic model(input logic [7:0] fcr, input int nsyn, input int n);
        logic [7:0] root, s;
        exp_nz = 0;
        for (int k = 0; k < 32; k++) exp_syn[k] = 0;
        for (int k = 0; k < nsyn; k++) begin
            root = gmul(fcr, 8'(exp_tab[k]));
            s = 0;
            for (int d = 0; d < n; d++) s = s ^ gmul(blk[n-1-d], gpow(root, d));
            exp_syn[k] = s;
            if (s != 0) exp_nz = 1;
        end
    endtask

    task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        blk[0] = a; blk[1] = b; blk[2] = c; blk[3] = d;
    endtask

    task automatic do_start(input logic [7:0] poly, input logic [7:0] fcr, input logic [5:0] nsyn, input logic [7:0] n);
        cfg_prim_poly = poly; cfg_first_root = fcr; cfg_nsyn = nsyn; cfg_block_len = n;
        start = 1;
        @(negedge clk);
        start = 0;
        start_cyc = cyc_cnt;
        cfg_prim_poly = 8'($urandom); cfg_first_root = 8'($urandom);
        cfg_nsyn = 6'($urandom); cfg_block_len = 8'($urandom);
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic send(input int n, input bit gaps);
        int  i, w;
        bit  acc;
        i = 0; w = 0;
        while (i < n && w < 20000) begin
            vif.in_valid = !(gaps && $urandom_range(0, 2) == 0);
            vif.in_data  = blk[i];
            acc = vif.in_valid && vif.in_ready;
            @(negedge clk);
            w++;
            if (acc) i++;
        end
        vif.in_valid = 0;
        chk("send_count", 32'(i), 32'(n));
    endtask

    task automatic collect(input int nsyn, input bit bp);
        int k, w;
        bit first;
        k = 0; w = 0; first = 1;
        while (k < nsyn && w < 20000) begin
            vif.syn_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (vif.syn_valid && first) begin
                first_lat = cyc_cnt - start_cyc;
                first = 0;
            end
            if (vif.syn_valid && vif.syn_ready) begin
                chk($sformatf("syn_data[%0d]", k), 32'(vif.syn_data), 32'(exp_syn[k]));
                chk("syn_index", 32'(vif.syn_index), 32'(k));
                chk("syn_last", 32'(vif.syn_last), 32'(k == nsyn - 1));
                chk("syn_nonzero", 32'(vif.syn_nonzero), 32'(exp_nz));
                chk("done_early", 32'(done), 0);
                k++;
            end
            @(negedge clk);
            w++;
        end
        vif.syn_ready = 0;
        chk("collect_count", 32'(k), 32'(nsyn));
        chk("done_pulse", 32'(done), 1);
        chk("busy_after_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    task automatic run(input logic [7:0] poly, input logic [7:0] fcr, input int nsyn, input int n, input bit gaps, input bit bp);
        build(poly);
        model(fcr, nsyn, n);
        do_start(poly, fcr, 6'(nsyn), 8'(n));
        send(n, gaps);
        collect(nsyn, bp);
    endtask

    task automatic reject(input logic [5:0] nsyn, input logic [7:0] n, input string tag);
        cfg_prim_poly = 8'h1D; cfg_first_root = 8'h02; cfg_nsyn = nsyn; cfg_block_len = n;
        start = 1;
        @(negedge clk);
        start = 0;
        chk({tag, "_cfg_err"}, 32'(cfg_err), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, "_cfg_err_clear"}, 32'(cfg_err), 0);
    endtask

    initial begin
        int w;
        vif.in_valid = 0; vif.in_data = 0; vif.syn_ready = 0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1;
        @(negedge clk);

        set4(8'h00, 8'h00, 8'h00, 8'h00);
        run(8'h1D, 8'h02, 2, 4, 0, 0);
        chk("zero_S0", 32'(exp_syn[0]), 0);
        set4(8'h01, 8'h00, 8'h00, 8'h00);
        run(8'h1D, 8'h02, 2, 4, 0, 0);
        chk("model_r3_S0", 32'(exp_syn[0]), 32'h08);
        chk("model_r3_S1", 32'(exp_syn[1]), 32'h40);
        set4(8'h00, 8'h00, 8'h01, 8'h00);
        run(8'h1D, 8'h02, 2, 4, 0, 0);
        set4(8'h00, 8'h00, 8'h00, 8'h01);
        run(8'h1D, 8'h02, 2, 4, 0, 0);
        chk("first_valid_latency", 32'(first_lat), 12);

        // backpressure: outputs hold for 5 cycles of syn_ready low
        for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
        build(8'h1D);
        model(8'h02, 2, 4);
        do_start(8'h1D, 8'h02, 6'd2, 8'd4);
        send(4, 0);
        w = 0;
        while (!vif.syn_valid && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", 32'(vif.syn_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", 32'(vif.syn_data), 32'(exp_syn[0]));
            chk("bp_hold_index", 32'(vif.syn_index), 0);
            @(negedge clk);
        end
        collect(2, 0);

        // the same random block with and without input gaps
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
        run(8'h1D, 8'h02, 6, 16, 0, 0);
        run(8'h1D, 8'h02, 6, 16, 1, 1);

        reject(6'd0, 8'd4, "nsyn0");
        reject(6'd33, 8'd4, "nsyn33");
        reject(6'd2, 8'd0, "len0");

        // start while busy is ignored
        build(8'h1D);
        set4(8'h01, 8'h00, 8'h00, 8'h00);
        model(8'h02, 2, 4);
        do_start(8'h1D, 8'h02, 6'd2, 8'd4);
        cfg_nsyn = 0; cfg_first_root = 8'h55; start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_start_no_err", 32'(cfg_err), 0);
        chk("busy_start_still_busy", 32'(busy), 1);
        send(4, 0);
        collect(2, 0);

        // abort after two bytes
        set4(8'h09, 8'h08, 8'h07, 8'h06);
        do_start(8'h1D, 8'h02, 6'd2, 8'd4);
        send(2, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_syn_valid", 32'(vif.syn_valid), 0);
        cfg_nsyn = 2; cfg_block_len = 4; start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("abort_wins_busy", 32'(busy), 0);
        chk("abort_wins_cfg_err", 32'(cfg_err), 0);
        set4(8'h01, 8'h00, 8'h00, 8'h00);
        run(8'h1D, 8'h02, 2, 4, 0, 0);

        // asynchronous reset in the middle of ACC
        set4(8'h33, 8'h44, 8'h55, 8'h66);
        do_start(8'h1D, 8'h02, 6'd8, 8'd4);
        send(1, 0);
        chk("mid_acc_busy", 32'(busy), 1);
        rst_n = 0;
        #1;
        chk_idle("rst_mid");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        set4(8'h01, 8'h00, 8'h00, 8'h00);
        run(8'h1D, 8'h02, 2, 4, 0, 0);

        // boundaries: longest block, widest syndrome set
        for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
        run(8'h1D, 8'h02, 1, 255, 0, 0);
        run(8'h2B, 8'h03, 32, 12, 1, 1);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
            run(polys[$urandom_range(0, 2)], 8'($urandom), $urandom_range(1, 32), $urandom_range(1, 40),
                1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
